quadrature_encoder_tx: RTL and testbench

Quadrature encoder transmitter: converts a commanded number of quadrature edges, direction and edge spacing into registered, glitch-free A/B/I encoder waveforms. It drives the external encoder inputs of a quadrature encoder channel, or a downstream motor-controller input, for closed-loop test and encoder emulation. It tracks emitted position and revolution phase so that a matching decoder counts exactly `position`. Commands arrive on a valid/ready handshake from the register/bus front end.

---
 rtl/quadrature_encoder_tx.sv | 181 ++++++++++++++++++
 tb/tb_quadrature_encoder_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_encoder_tx.sv
// Quadrature encoder transmitter: emits a commanded number of A/B edges at a fixed spacing,
// tracks signed position and revolution phase, and pulses an index output once per revolution.
module quadrature_encoder_tx #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CNT_WIDTH-1:0] cmd_steps,
  input  logic                 cmd_dir,
  input  logic [CNT_WIDTH-1:0] phase_time,
  input  logic [CNT_WIDTH-1:0] counts_per_rev,
  input  logic                 flip_AB,
  input  logic                 abort,
  input  logic                 position_clear,
  output logic                 qe_a,
  output logic                 qe_b,
  output logic                 qe_i,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] position,
  output logic [CNT_WIDTH-1:0] steps_remaining
);

  localparam logic [CNT_WIDTH-1:0] Zero = '0;
  localparam logic [CNT_WIDTH-1:0] One  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [CNT_WIDTH-1:0] pos_q, pos_d;
  logic [CNT_WIDTH-1:0] rev_q, rev_d;
  logic [CNT_WIDTH-1:0] steps_q, steps_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 dir_q, dir_d;
  logic                 aborted_q, aborted_d;
  logic                 qe_a_q, qe_a_d;
  logic                 qe_b_q, qe_b_d;
  logic                 qe_i_q, qe_i_d;

  logic                 step;
  logic [CNT_WIDTH-1:0] period_eff;
  logic                 phase_a;
  logic                 phase_b;

  // A zero spacing would stall the timer, so it behaves as one clock per edge.
  assign period_eff = (phase_time == Zero) ? One : phase_time;

  always_comb begin
    state_d   = state_q;
    steps_d   = steps_q;
    timer_d   = timer_q;
    period_d  = period_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    step      = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid && enable) begin
          steps_d   = cmd_steps;
          timer_d   = period_eff;
          period_d  = period_eff;
          dir_d     = cmd_dir;
          aborted_d = 1'b0;
          state_d   = (cmd_steps == Zero) ? StDone : StRun;
        end
      end
      StRun: begin
        if (enable) begin
          if (abort) begin
            // Abort beats a step falling due in the same cycle.
            aborted_d = 1'b1;
            state_d   = StDone;
          end else if (timer_q == One) begin
            step    = 1'b1;
            steps_d = steps_q - One;
            timer_d = period_q;
            if (steps_q == One) begin
              state_d = StDone;
            end
          end else begin
            timer_d = timer_q - One;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    pos_d   = pos_q;
    rev_d   = rev_q;

    if (step) begin
      phase_d = dir_q ? (phase_q - 2'd1) : (phase_q + 2'd1);
      pos_d   = dir_q ? (pos_q - One) : (pos_q + One);
    end

    if (position_clear) begin
      pos_d = Zero;
    end

    // Out-of-range covers a shrunk counts_per_rev and also pins rev_pos at 0 when it is 0.
    if (position_clear || (rev_q >= counts_per_rev)) begin
      rev_d = Zero;
    end else if (step) begin
      if (!dir_q) begin
        rev_d = (rev_q == counts_per_rev - One) ? Zero : (rev_q + One);
      end else begin
        rev_d = (rev_q == Zero) ? (counts_per_rev - One) : (rev_q - One);
      end
    end
  end

  // Gray sequence 00,10,11,01 for phases 0..3, written as {A,B}.
  assign phase_a = phase_d[0] ^ phase_d[1];
  assign phase_b = phase_d[1];

  always_comb begin
    qe_a_d = flip_AB ? phase_b : phase_a;
    qe_b_d = flip_AB ? phase_a : phase_b;
    qe_i_d = (counts_per_rev != Zero) && (rev_q == Zero);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      phase_q   <= 2'd0;
      pos_q     <= Zero;
      rev_q     <= Zero;
      steps_q   <= Zero;
      timer_q   <= Zero;
      period_q  <= Zero;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
      qe_a_q    <= 1'b0;
      qe_b_q    <= 1'b0;
      qe_i_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      rev_q     <= rev_d;
      steps_q   <= steps_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
      qe_a_q    <= qe_a_d;
      qe_b_q    <= qe_b_d;
      qe_i_q    <= qe_i_d;
    end
  end

  assign cmd_ready       = (state_q == StIdle) && enable;
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);
  assign aborted         = aborted_q;
  assign qe_a            = qe_a_q;
  assign qe_b            = qe_b_q;
  assign qe_i            = qe_i_q;
  assign position        = pos_q;
  assign steps_remaining = steps_q;

endmodule

// File: tb/tb_quadrature_encoder_tx.sv
// Bench for quadrature_encoder_tx: an event-scheduled model checked every cycle, plus
// directed commands with hand-computed literal expectations.
module tb_quadrature_encoder_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_steps;
  logic        cmd_dir;
  logic [31:0] phase_time;
  logic [31:0] counts_per_rev;
  logic        flip_AB;
  logic        abort;
  logic        position_clear;
  logic        qe_a, qe_b, qe_i, busy, done, aborted;
  logic [31:0] position;
  logic [31:0] steps_remaining;

  // Narrow instance so signed wrap can be reached with a handful of steps.
  logic       s_valid, s_ready, s_dir, s_flip, s_abort, s_clear;
  logic [3:0] s_steps, s_pt, s_cpr;
  logic       s_a, s_b, s_i, s_busy, s_done, s_aborted;
  logic [3:0] s_pos, s_rem;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  quadrature_encoder_tx #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .phase_time(phase_time),
    .counts_per_rev(counts_per_rev), .flip_AB(flip_AB), .abort(abort),
    .position_clear(position_clear), .qe_a(qe_a), .qe_b(qe_b), .qe_i(qe_i), .busy(busy),
    .done(done), .aborted(aborted), .position(position), .steps_remaining(steps_remaining)
  );

  quadrature_encoder_tx #(.CNT_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset), .enable(1'b1), .cmd_valid(s_valid), .cmd_ready(s_ready),
    .cmd_steps(s_steps), .cmd_dir(s_dir), .phase_time(s_pt), .counts_per_rev(s_cpr),
    .flip_AB(s_flip), .abort(s_abort), .position_clear(s_clear), .qe_a(s_a), .qe_b(s_b),
    .qe_i(s_i), .busy(s_busy), .done(s_done), .aborted(s_aborted), .position(s_pos),
    .steps_remaining(s_rem)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: steps scheduled by absolute cycle number ----------------
  longint      cyc = 0;
  int          m_mode;      // 0 idle, 1 run, 2 done
  longint      m_next;
  longint      m_p;
  logic [31:0] m_left;
  logic        m_dir;
  logic        m_aborted;
  logic [31:0] m_pos;
  longint      m_rev;
  int          m_phase;
  logic        exp_a, exp_b, exp_i;
  logic [1:0]  ab_tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_next = 0; m_p = 1; m_left = '0; m_dir = 1'b0; m_aborted = 1'b0;
      m_pos = '0; m_rev = 0; m_phase = 0; exp_a = 1'b0; exp_b = 1'b0; exp_i = 1'b0;
    end else begin
      logic   stepped;
      logic   nidx;
      logic [1:0] ab;
      int     d;
      cyc++;
      stepped = 1'b0;
      nidx    = (counts_per_rev != 0) && (m_rev == 0);
      case (m_mode)
        0: if (cmd_valid && enable) begin
          m_left    = cmd_steps;
          m_p       = (phase_time == 0) ? 1 : longint'(phase_time);
          m_dir     = cmd_dir;
          m_aborted = 1'b0;
          m_next    = cyc + m_p;
          m_mode    = (cmd_steps == 0) ? 2 : 1;
        end
        1: if (!enable) m_next++;
           else if (abort) begin m_mode = 2; m_aborted = 1'b1; end
           else if (cyc == m_next) begin
             stepped = 1'b1;
             m_left  = m_left - 1;
             m_next  = m_next + m_p;
             if (m_left == 0) m_mode = 2;
           end
        default: m_mode = 0;
      endcase
      d = m_dir ? -1 : 1;
      if (stepped) begin
        m_phase = (m_phase + d + 4) % 4;
        m_pos   = m_pos + 32'(d);
      end
      if (position_clear) m_pos = '0;
      if (position_clear || counts_per_rev == 0 || m_rev >= longint'(counts_per_rev)) m_rev = 0;
      else if (stepped)
        m_rev = (m_rev + longint'(counts_per_rev) + d) % longint'(counts_per_rev);
      ab    = ab_tbl[m_phase];
      exp_a = flip_AB ? ab[0] : ab[1];
      exp_b = flip_AB ? ab[1] : ab[0];
      exp_i = nidx;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("qe_a", 32'(qe_a), 32'(exp_a));
      chk("qe_b", 32'(qe_b), 32'(exp_b));
      chk("qe_i", 32'(qe_i), 32'(exp_i));
      chk("done", 32'(done), 32'(m_mode == 2));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0 && enable));
      chk("aborted", 32'(aborted), 32'(m_aborted));
      chk("position", position, m_pos);
      chk("steps_remaining", steps_remaining, m_left);
    end
  end

  // ---------------- stimulus helpers (called just after a rising edge) ----------------
  longint t0;

  task automatic send(input logic [31:0] n, input logic d, input logic [31:0] pt);
    int i = 0;
    cmd_steps = n; cmd_dir = d; phase_time = pt; cmd_valid = 1'b1;
    while (!cmd_ready && i < 200) begin @(posedge clk); #1; i++; end
    if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string nm);
    int i = 0;
    do begin @(negedge clk); i++; end while (!done && i < 500);
    if (!done) chk(nm, 32'(done), 32'd1);
  endtask

  task automatic pulse_clear();
    position_clear = 1'b1; @(posedge clk); #1; position_clear = 1'b0;
  endtask

  task automatic s_send(input logic [3:0] n);
    int i = 0;
    s_steps = n; s_valid = 1'b1;
    while (!s_ready && i < 200) begin @(posedge clk); #1; i++; end
    if (!s_ready) chk("s_send_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic s_wait_done(input string nm);
    int i = 0;
    do begin @(negedge clk); i++; end while (!s_done && i < 200);
    if (!s_done) chk(nm, 32'(s_done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0;
    phase_time = '0; counts_per_rev = '0; flip_AB = 1'b0; abort = 1'b0; position_clear = 1'b0;
    s_valid = 1'b0; s_dir = 1'b0; s_flip = 1'b0; s_abort = 1'b0; s_clear = 1'b0;
    s_steps = '0; s_pt = 4'd1; s_cpr = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_ab", 32'({qe_a, qe_b}), 32'b00);
    chk("rst_i", 32'(qe_i), 32'd0);
    chk("rst_pos", position, 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // CW 8 steps, spacing 4
    send(32'd8, 1'b0, 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("cw_first_ab", 32'({qe_a, qe_b}), 32'b10);
    chk("cw_first_pos", position, 32'd1);
    wait_done("cw_done_timeout");
    chk("cw_end_pos", position, 32'd8);
    chk("cw_end_ab", 32'({qe_a, qe_b}), 32'b00);
    @(posedge clk); #1;

    // CCW 8 steps from a cleared position
    pulse_clear();
    send(32'd8, 1'b1, 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ccw_first_ab", 32'({qe_a, qe_b}), 32'b01);
    chk("ccw_first_pos", position, 32'hFFFF_FFFF);
    wait_done("ccw_done_timeout");
    chk("ccw_end_pos", position, 32'hFFFF_FFF8);
    @(posedge clk); #1;

    // Index with 4 counts per revolution, then back with A/B flipped
    pulse_clear();
    counts_per_rev = 32'd4;
    send(32'd10, 1'b0, 32'd1);
    wait_done("idx_cw_timeout");
    chk("idx_cw_pos", position, 32'd10);
    chk("idx_cw_ab", 32'({qe_a, qe_b}), 32'b11);
    @(posedge clk); #1;
    flip_AB = 1'b1;
    send(32'd10, 1'b1, 32'd1);
    wait_done("idx_ccw_timeout");
    chk("idx_ccw_pos", position, 32'd0);
    @(posedge clk); #1;
    flip_AB = 1'b0;

    // Abort on the edge where the third step falls due
    pulse_clear();
    send(32'd6, 1'b0, 32'd3);
    repeat (8) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_flag", 32'(aborted), 32'd1);
    chk("abort_pos", position, 32'd2);
    chk("abort_left", steps_remaining, 32'd4);
    @(posedge clk); #1;
    counts_per_rev = 32'd0;
    @(negedge clk);
    chk("abort_sticky", 32'(aborted), 32'd1);
    @(posedge clk); #1;

    // Zero-step command, then a paused run
    send(32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    send(32'd4, 1'b0, 32'd3);
    repeat (4) @(posedge clk);
    #1 enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 enable = 1'b1;
    wait_done("pause_timeout");
    chk("pause_latency", 32'(cyc - t0), 32'd17);
    @(posedge clk); #1;

    // Asynchronous reset mid-run
    send(32'd20, 1'b0, 32'd2);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pos", position, 32'd0);
    chk("arst_left", steps_remaining, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Signed wrap on the 4-bit instance: 7 then one step with clear, 7 then one without
    s_send(4'd7);
    s_wait_done("s1_timeout");
    chk("s_pos7", 32'(s_pos), 32'h7);
    chk("s_ab7", 32'({s_a, s_b}), 32'b01);
    @(posedge clk); #1;
    s_send(4'd1);
    s_clear = 1'b1;
    @(posedge clk);
    #1 s_clear = 1'b0;
    @(negedge clk);
    chk("s_clear_pos", 32'(s_pos), 32'h0);
    chk("s_clear_ab", 32'({s_a, s_b}), 32'b00);
    @(posedge clk); #1;
    s_send(4'd7);
    s_wait_done("s3_timeout");
    @(posedge clk); #1;
    s_send(4'd1);
    s_wait_done("s4_timeout");
    chk("s_wrap_pos", 32'(s_pos), 32'h8);
    chk("s_wrap_ab", 32'({s_a, s_b}), 32'b00);
    chk("s_rem", 32'(s_rem), 32'h0);
    chk("s_aborted", 32'(s_aborted), 32'd0);
    chk("s_i", 32'(s_i), 32'd0);
    chk("s_busy", 32'(s_busy), 32'd1);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
